// File: rtl/reduction_rr_arbiter.sv
// Round-robin arbiter that drains seven show-ahead FIFOs into a single registered output stream.
// Optional per-source grant counters are enabled by defining REDUCTION_ARB_GRANT_CNT_EN.
module reduction_rr_arbiter #(
    parameter int DATA_W  = 64,
    parameter int NUM_SRC = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        fifo_empty,
    input  logic [NUM_SRC*DATA_W-1:0] fifo_data,
    input  logic [NUM_SRC-1:0]        fifo_last,
    output logic [NUM_SRC-1:0]        fifo_pop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [2:0]                out_src,
    output logic                      out_last
`ifdef REDUCTION_ARB_GRANT_CNT_EN
    ,
    input  logic [2:0]                cnt_sel,
    input  logic                      cnt_clr,
    output logic [31:0]               cnt_val
`endif
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    localparam logic [2:0] IDX_NONE = 3'd7;

    state_t              state_q, state_d;
    logic [2:0]          cur_idx_q, cur_idx_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [2:0]          out_src_q, out_src_d;
    logic                out_last_q, out_last_d;

    logic [NUM_SRC:0]    avail;
    logic                load;
    logic [2:0]          next_idx;
    logic [3:0]          cand;
    logic                grant_en;
    logic [2:0]          grant_idx;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;

    // Extra top bit stands for the "none" index so it always reads as unavailable.
    assign avail = {1'b0, ~fifo_empty};
    assign load  = ~out_valid_q | out_ready;

    // Loops run in reverse so the earliest candidate in search order is the final assignment.
    always_comb begin
        next_idx = IDX_NONE;
        cand     = '0;
        if (cur_idx_q == IDX_NONE) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                if (avail[k]) next_idx = 3'(k);
            end
        end else begin
            for (int k = NUM_SRC; k >= 1; k--) begin
                cand = {1'b0, cur_idx_q} + 4'(k);
                if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
                if (avail[cand[2:0]]) next_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        fifo_pop    = '0;
        grant_en    = 1'b0;
        grant_idx   = IDX_NONE;
        sel_data    = '0;
        sel_last    = 1'b0;

        if (load) begin
            case (state_q)
                ST_ARB: begin
                    if (next_idx != IDX_NONE) begin
                        grant_en  = 1'b1;
                        grant_idx = next_idx;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_LOCK: begin
                    if (avail[cur_idx_q]) begin
                        grant_en  = 1'b1;
                        grant_idx = cur_idx_q;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                default: out_valid_d = 1'b0;
            endcase
        end

        if (grant_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_idx == 3'(i)) begin
                    fifo_pop[i] = 1'b1;
                    sel_data    = fifo_data[i*DATA_W +: DATA_W];
                    sel_last    = fifo_last[i];
                end
            end
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = grant_idx;
            out_last_d  = sel_last;
            cur_idx_d   = grant_idx;
            state_d     = sel_last ? ST_ARB : ST_LOCK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            cur_idx_q   <= IDX_NONE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

`ifdef REDUCTION_ARB_GRANT_CNT_EN
    logic [31:0] cnt_q [NUM_SRC];
    logic [31:0] cnt_d [NUM_SRC];
    logic [31:0] cnt_val_q, cnt_val_d;

    // Clear takes priority over a same-cycle pop; counters wrap naturally.
    always_comb begin
        cnt_val_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = cnt_clr ? 32'd0 : cnt_q[i] + {31'd0, fifo_pop[i]};
            if (cnt_sel == 3'(i)) cnt_val_d = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
            cnt_val_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
            cnt_val_q <= cnt_val_d;
        end
    end

    assign cnt_val = cnt_val_q;
`endif

endmodule

// File: tb/tb_reduction_rr_arbiter.sv
// Directed bench for reduction_rr_arbiter: a per-cycle vector table plus FIFO-model sequences.
// Grant-counter checks are compiled in when REDUCTION_ARB_GRANT_CNT_EN is defined.
module tb_reduction_rr_arbiter;

    localparam int DW = 64;
    localparam int NS = 7;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    fifo_empty;
    logic [NS*DW-1:0] fifo_data;
    logic [NS-1:0]    fifo_last;
    logic [NS-1:0]    fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [2:0]       out_src;
    logic             out_last;
`ifdef REDUCTION_ARB_GRANT_CNT_EN
    logic [2:0]       cnt_sel;
    logic             cnt_clr;
    logic [31:0]      cnt_val;
`endif

    int checks = 0;
    int errors = 0;

    reduction_rr_arbiter #(.DATA_W(DW), .NUM_SRC(NS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_last  (fifo_last),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_last   (out_last)
`ifdef REDUCTION_ARB_GRANT_CNT_EN
        ,
        .cnt_sel    (cnt_sel),
        .cnt_clr    (cnt_clr),
        .cnt_val    (cnt_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] empty;
        logic [6:0] last;
        logic       ready;
        logic [6:0] exp_pop;
        logic       exp_valid;
        logic [2:0] exp_src;
        logic       exp_last;
        int         exp_step;
    } vec_t;

    vec_t vecs [18];

    // FIFO model for the multi-cycle sequences, plus the expected grant order.
    logic [63:0] qd [NS][8];
    logic        ql [NS][8];
    int          qh [NS];
    int          qc [NS];
    logic [63:0] ed [32];
    logic [2:0]  es [32];
    logic        el [32];
    int          ew;
    int          er;

    function automatic logic [63:0] word(input int step, input int src);
        return {16'hBEEF, 16'(step), 29'd0, 3'(src)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] empty, input logic [6:0] last,
                                 input logic ready, input int step);
        fifo_empty = empty;
        fifo_last  = last;
        out_ready  = ready;
        for (int i = 0; i < NS; i++) fifo_data[i*DW +: DW] = word(step, i);
        #1;
    endtask

    task automatic resetDut();
        rst_n      = 1'b0;
        fifo_empty = 7'h7F;
        fifo_last  = 7'h7F;
        fifo_data  = '0;
        out_ready  = 1'b1;
        #2;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_src", 64'(out_src), 64'd0);
        checkOutput("reset out_data", out_data, 64'd0);
        checkOutput("reset out_last", 64'(out_last), 64'd0);
        checkOutput("reset fifo_pop", 64'(fifo_pop), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < NS; f++) begin
            qh[f] = 0;
            qc[f] = 0;
        end
        ew = 0;
        er = 0;
    endtask

    task automatic pushWord(input int f, input logic [63:0] d, input logic l);
        qd[f][qh[f] + qc[f]] = d;
        ql[f][qh[f] + qc[f]] = l;
        qc[f]++;
    endtask

    task automatic expectWord(input int f, input logic [63:0] d, input logic l);
        es[ew] = 3'(f);
        ed[ew] = d;
        el[ew] = l;
        ew++;
    endtask

    task automatic stepQ(input logic ready, input logic [6:0] hole, output logic [6:0] popped);
        for (int i = 0; i < NS; i++) begin
            fifo_empty[i] = (qc[i] == 0) || hole[i];
            fifo_data[i*DW +: DW] = (qc[i] != 0) ? qd[i][qh[i]] : 64'd0;
            fifo_last[i] = (qc[i] != 0) ? ql[i][qh[i]] : 1'b0;
        end
        out_ready = ready;
        #1;
        popped = fifo_pop;
        checkOutput("pop of empty fifo", 64'(popped & fifo_empty), 64'd0);
        checkOutput("pop not one-hot", 64'($countones(popped) > 1), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (popped[i] && qc[i] > 0) begin
                qh[i]++;
                qc[i]--;
            end
        end
        if (popped != 7'd0) begin
            if (er >= ew) begin
                checkOutput("unexpected grant", 64'(popped), 64'd0);
            end else begin
                checkOutput($sformatf("grant %0d out_src", er), 64'(out_src), 64'(es[er]));
                checkOutput($sformatf("grant %0d out_data", er), out_data, ed[er]);
                checkOutput($sformatf("grant %0d out_last", er), 64'(out_last), 64'(el[er]));
                checkOutput($sformatf("grant %0d out_valid", er), 64'(out_valid), 64'd1);
                er++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0]  p;
        logic [63:0] d;

        rst_n      = 1'b0;
        fifo_empty = 7'h7F;
        fifo_last  = 7'h7F;
        fifo_data  = '0;
        out_ready  = 1'b1;
`ifdef REDUCTION_ARB_GRANT_CNT_EN
        cnt_sel    = 3'd0;
        cnt_clr    = 1'b0;
`endif

        //             empty  last   rdy  pop    v     src   l     step
        vecs[0]  = '{7'h7F, 7'h7F, 1'b1, 7'h00, 1'b0, 3'd0, 1'b0, 0};
        vecs[1]  = '{7'h7F, 7'h7F, 1'b1, 7'h00, 1'b0, 3'd0, 1'b0, 0};
        vecs[2]  = '{7'h6B, 7'h7F, 1'b1, 7'h04, 1'b1, 3'd2, 1'b1, 2};
        vecs[3]  = '{7'h6B, 7'h7F, 1'b1, 7'h10, 1'b1, 3'd4, 1'b1, 3};
        vecs[4]  = '{7'h6B, 7'h7F, 1'b1, 7'h04, 1'b1, 3'd2, 1'b1, 4};
        vecs[5]  = '{7'h3E, 7'h7F, 1'b1, 7'h40, 1'b1, 3'd6, 1'b1, 5};
        vecs[6]  = '{7'h3E, 7'h7F, 1'b1, 7'h01, 1'b1, 3'd0, 1'b1, 6};
        vecs[7]  = '{7'h7E, 7'h7F, 1'b1, 7'h01, 1'b1, 3'd0, 1'b1, 7};
        vecs[8]  = '{7'h7F, 7'h7F, 1'b1, 7'h00, 1'b0, 3'd0, 1'b0, 0};
        vecs[9]  = '{7'h5D, 7'h7D, 1'b0, 7'h02, 1'b1, 3'd1, 1'b0, 9};
        vecs[10] = '{7'h5D, 7'h7D, 1'b0, 7'h00, 1'b1, 3'd1, 1'b0, 9};
        vecs[11] = '{7'h5F, 7'h7D, 1'b1, 7'h00, 1'b0, 3'd0, 1'b0, 0};
        vecs[12] = '{7'h5F, 7'h7D, 1'b1, 7'h00, 1'b0, 3'd0, 1'b0, 0};
        vecs[13] = '{7'h5D, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 1'b1, 13};
        vecs[14] = '{7'h5D, 7'h7F, 1'b1, 7'h20, 1'b1, 3'd5, 1'b1, 14};
        vecs[15] = '{7'h5D, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd5, 1'b1, 14};
        vecs[16] = '{7'h5D, 7'h7F, 1'b0, 7'h00, 1'b1, 3'd5, 1'b1, 14};
        vecs[17] = '{7'h5D, 7'h7F, 1'b1, 7'h02, 1'b1, 3'd1, 1'b1, 17};

        resetDut();

        for (int s = 0; s < 18; s++) begin
            applyStimulus(vecs[s].empty, vecs[s].last, vecs[s].ready, s);
            checkOutput($sformatf("vec %0d fifo_pop", s), 64'(fifo_pop), 64'(vecs[s].exp_pop));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec %0d out_valid", s), 64'(out_valid), 64'(vecs[s].exp_valid));
            if (vecs[s].exp_valid) begin
                checkOutput($sformatf("vec %0d out_src", s), 64'(out_src), 64'(vecs[s].exp_src));
                checkOutput($sformatf("vec %0d out_last", s), 64'(out_last), 64'(vecs[s].exp_last));
                checkOutput($sformatf("vec %0d out_data", s), out_data,
                            word(vecs[s].exp_step, int'(vecs[s].exp_src)));
            end
        end

        // Fairness: every FIFO holds two single-beat words, sources must rotate 0..6 twice.
        resetDut();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NS; i++) begin
                d = {16'hF0F0, 8'(i), 8'(k), 32'd0};
                pushWord(i, d, 1'b1);
                expectWord(i, d, 1'b1);
            end
        end
        for (int c = 0; c < 14; c++) begin
            stepQ(1'b1, 7'h00, p);
            checkOutput($sformatf("fair cycle %0d popped", c), 64'(p != 7'd0), 64'd1);
        end
        stepQ(1'b1, 7'h00, p);
        checkOutput("fair drained out_valid", 64'(out_valid), 64'd0);
        checkOutput("fair grants consumed", 64'(er), 64'(ew));

        // Single non-empty FIFO keeps regranting itself.
        for (int k = 0; k < 3; k++) begin
            d = {16'h4444, 16'(k), 32'h1234_5678};
            pushWord(4, d, 1'b1);
            expectWord(4, d, 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            stepQ(1'b1, 7'h00, p);
            checkOutput($sformatf("regrant %0d pop", c), 64'(p), 64'h10);
        end
        stepQ(1'b1, 7'h00, p);
        checkOutput("regrant grants consumed", 64'(er), 64'(ew));

        // Multi-beat record on FIFO 2 with FIFO 3 waiting; FIFO 2 runs dry mid-record.
        for (int k = 0; k < 3; k++) begin
            d = {16'h2222, 16'(k), 32'hAAAA_0000};
            pushWord(2, d, (k == 2));
            expectWord(2, d, (k == 2));
        end
        for (int k = 0; k < 2; k++) begin
            d = {16'h3333, 16'(k), 32'hBBBB_0000};
            pushWord(3, d, 1'b1);
        end
        for (int k = 0; k < 2; k++) expectWord(3, {16'h3333, 16'(k), 32'hBBBB_0000}, 1'b1);
        stepQ(1'b1, 7'h00, p);
        checkOutput("lock first beat pop", 64'(p), 64'h04);
        for (int c = 0; c < 2; c++) begin
            stepQ(1'b1, 7'h04, p);
            checkOutput($sformatf("lock bubble %0d pop", c), 64'(p), 64'd0);
            checkOutput($sformatf("lock bubble %0d out_valid", c), 64'(out_valid), 64'd0);
        end
        for (int c = 0; c < 5; c++) stepQ(1'b1, 7'h00, p);
        checkOutput("lock grants consumed", 64'(er), 64'(ew));

        // Downstream stall: output must hold and nothing may pop.
        for (int k = 0; k < 3; k++) begin
            d = {16'h5555, 16'(k), 32'hCCCC_0000};
            pushWord(5, d, 1'b1);
            expectWord(5, d, 1'b1);
        end
        stepQ(1'b1, 7'h00, p);
        for (int c = 0; c < 5; c++) begin
            stepQ(1'b0, 7'h00, p);
            checkOutput($sformatf("stall %0d pop", c), 64'(p), 64'd0);
            checkOutput($sformatf("stall %0d out_valid", c), 64'(out_valid), 64'd1);
            checkOutput($sformatf("stall %0d out_data", c), out_data, {16'h5555, 16'd0, 32'hCCCC_0000});
        end
        for (int c = 0; c < 3; c++) stepQ(1'b1, 7'h00, p);
        checkOutput("stall grants consumed", 64'(er), 64'(ew));

`ifdef REDUCTION_ARB_GRANT_CNT_EN
        resetDut();
        for (int k = 0; k < 5; k++) begin
            d = {16'h1111, 16'(k), 32'd0};
            pushWord(1, d, 1'b1);
            expectWord(1, d, 1'b1);
        end
        for (int c = 0; c < 5; c++) stepQ(1'b1, 7'h00, p);
        cnt_sel = 3'd1;
        stepQ(1'b1, 7'h00, p);
        checkOutput("cnt_val after 5 pops", 64'(cnt_val), 64'd5);
        cnt_clr = 1'b1;
        stepQ(1'b1, 7'h00, p);
        cnt_clr = 1'b0;
        stepQ(1'b1, 7'h00, p);
        checkOutput("cnt_val after clear", 64'(cnt_val), 64'd0);
        cnt_sel = 3'd7;
        stepQ(1'b1, 7'h00, p);
        checkOutput("cnt_val sel none", 64'(cnt_val), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
